// File: rtl/vector_addsub_seq.sv
// Sequential element-wise add/subtract of two packed vectors, LANES elements per cycle,
// with per-element wrap or saturate and a sticky signed-overflow flag per operation.
module vector_addsub_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SIZE  = 4,
  parameter int unsigned LANES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  sub,
  input  logic                  sat,
  input  logic [WIDTH*SIZE-1:0] a,
  input  logic [WIDTH*SIZE-1:0] b,
  output logic [WIDTH*SIZE-1:0] y,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf
);

  localparam int unsigned SafeLanes = (LANES == 0) ? 1 : LANES;
  localparam int unsigned N         = SIZE / SafeLanes;
  localparam int unsigned CntW      = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned VecW      = WIDTH * SIZE;

  if (LANES < 1 || SIZE < 1 || (SIZE % SafeLanes) != 0) begin : g_bad_lanes
    $error("vector_addsub_seq: LANES must be >= 1 and divide SIZE");
  end

  typedef enum logic {StIdle, StRun} state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [VecW-1:0]   a_q, b_q;
  logic              sub_q, sat_q;
  logic [VecW-1:0]   buf_q, buf_d;
  logic              ovf_acc_q, ovf_acc_d;
  logic              last;

  int unsigned       lane_idx [LANES];
  logic [WIDTH-1:0]  lane_val [LANES];
  logic [LANES-1:0]  lane_ovf;

  // Operands are sign-extended to WIDTH+1 bits so a - (-2^(WIDTH-1)) is exact.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [WIDTH-1:0]   a_el, b_el;
    logic signed [WIDTH:0] ea, eb, res;

    assign lane_idx[l] = 32'(cnt_q) * LANES + 32'(l);
    assign a_el        = a_q[lane_idx[l]*WIDTH +: WIDTH];
    assign b_el        = b_q[lane_idx[l]*WIDTH +: WIDTH];
    assign ea          = {a_el[WIDTH-1], a_el};
    assign eb          = {b_el[WIDTH-1], b_el};
    assign res         = sub_q ? (ea - eb) : (ea + eb);
    assign lane_ovf[l] = res[WIDTH] ^ res[WIDTH-1];

    always_comb begin
      lane_val[l] = res[WIDTH-1:0];
      if (sat_q && lane_ovf[l]) begin
        lane_val[l] = res[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      end
    end
  end

  // buf_d includes the group being computed this cycle, so the completing edge
  // can publish the whole vector at once.
  always_comb begin
    buf_d = buf_q;
    for (int l = 0; l < LANES; l++) begin
      buf_d[lane_idx[l]*WIDTH +: WIDTH] = lane_val[l];
    end
    ovf_acc_d = ovf_acc_q | (|lane_ovf);
  end

  assign last = (cnt_q == CntW'(N - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ovf     <= 1'b0;
      y       <= '0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            a_q       <= a;
            b_q       <= b;
            sub_q     <= sub;
            sat_q     <= sat;
            cnt_q     <= '0;
            ovf_acc_q <= 1'b0;
            busy      <= 1'b1;
            state_q   <= StRun;
          end
        end
        StRun: begin
          buf_q     <= buf_d;
          ovf_acc_q <= ovf_acc_d;
          cnt_q     <= cnt_q + 1'b1;
          if (last) begin
            y       <= buf_d;
            ovf     <= ovf_acc_d;
            done    <= 1'b1;
            busy    <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
